// File: rtl/sound_scheduler_pkg.sv
// Shared types and the clip map of the concatenated sound-effect sample ROM.
// Every clip region satisfies CLIP_BASE + CLIP_LEN <= 2**N_DEF and CLIP_LEN >= 1.
package sound_pkg;

  localparam int NSRC_DEF = 4;
  localparam int N_DEF    = 16;

  localparam int SND_JUMP    = 0;
  localparam int SND_SPRING  = 1;
  localparam int SND_MONSTER = 2;
  localparam int SND_FALL    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Element i describes source i (jump, spring, monster, fall).
  localparam logic [NSRC_DEF-1:0][N_DEF-1:0] CLIP_BASE = {16'h0200, 16'h0100, 16'h0040, 16'h0000};
  localparam logic [NSRC_DEF-1:0][N_DEF-1:0] CLIP_LEN  = {16'd48,   16'd5,    16'd12,   16'd8};

  function automatic logic [N_DEF-1:0] clip_last(input logic [$clog2(NSRC_DEF)-1:0] id);
    return CLIP_LEN[id] - 16'd1;
  endfunction

endpackage

// File: rtl/sound_scheduler_prio_enc.sv
// Lowest-index-wins priority encoder: valid_o flags any request, idx_o names the winner.
module prio_enc #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      idx_o = req_i[i] ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Grants the shared sample ROM to one sound clip at a time by fixed priority with
// preemption, and walks the granted clip's ROM addresses one sample per Sound_clk.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int N    = N_DEF
) (
  input  logic                    Sound_clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [NSRC-1:0]         Req,
  output logic [N-1:0]            Addr,
  output logic                    Sample_valid,
  output logic                    Busy,
  output logic [$clog2(NSRC)-1:0] Active_id,
  output logic [NSRC-1:0]         Done,
  output logic [NSRC-1:0]         Aborted
);

  localparam int IW = $clog2(NSRC);

  state_e           state_q;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC-1:0]  req_q;
  logic [NSRC-1:0]  clr_s;
  logic [IW-1:0]    id_q;
  logic [N-1:0]     base_q, last_q, offset_q, offset_d;
  logic [N-1:0]     addr_q;
  logic             valid_q, busy_q;
  logic [NSRC-1:0]  done_q, aborted_q;
  logic             win_valid_s;
  logic [IW-1:0]    win_idx_s;

  prio_enc #(.W(NSRC), .IW(IW)) u_prio_enc (
    .req_i   (pend_q),
    .valid_o (win_valid_s),
    .idx_o   (win_idx_s)
  );

  // A held Req counts once, so only its rising edge latches; a new request beats the LOAD clear.
  always_comb begin
    clr_s    = (state_q == LOAD && win_valid_s) ? (NSRC'(1) << win_idx_s) : '0;
    pend_d   = Enable ? ((pend_q & ~clr_s) | (Req & ~req_q)) : '0;
    offset_d = offset_q + N'(1);
  end

  // Sequencing FSM; all outputs are registered here.
  always_ff @(posedge Sound_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      req_q     <= '0;
      id_q      <= '0;
      base_q    <= '0;
      last_q    <= '0;
      offset_q  <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      aborted_q <= '0;
    end else begin
      req_q     <= Req;
      pend_q    <= pend_d;
      done_q    <= '0;
      aborted_q <= '0;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          busy_q  <= Enable && win_valid_s;
          state_q <= (Enable && win_valid_s) ? LOAD : IDLE;
        end
        LOAD: begin
          if (Enable && win_valid_s) begin
            id_q     <= win_idx_s;
            base_q   <= N'(CLIP_BASE[win_idx_s]);
            last_q   <= N'(clip_last(win_idx_s));
            offset_q <= '0;
            addr_q   <= N'(CLIP_BASE[win_idx_s]);
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= PLAY;
          end else begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        PLAY: begin
          if (!Enable) begin
            aborted_q[id_q] <= 1'b1;
            valid_q         <= 1'b0;
            busy_q          <= 1'b0;
            offset_q        <= '0;
            state_q         <= IDLE;
          end else if (offset_q == last_q) begin
            // The final sample always completes, even with a preemptor waiting.
            done_q[id_q]    <= 1'b1;
            valid_q         <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= FINISH;
          end else if (win_valid_s && (win_idx_s <= id_q)) begin
            aborted_q[id_q] <= 1'b1;
            valid_q         <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= LOAD;
          end else begin
            offset_q        <= offset_d;
            addr_q          <= base_q + offset_d;
            valid_q         <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= PLAY;
          end
        end
        FINISH: begin
          valid_q <= 1'b0;
          busy_q  <= Enable && win_valid_s;
          state_q <= (Enable && win_valid_s) ? LOAD : IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Addr         = addr_q;
  assign Sample_valid = valid_q;
  assign Busy         = busy_q;
  assign Active_id    = id_q;
  assign Done         = done_q;
  assign Aborted      = aborted_q;

endmodule
